// File: rtl/ram_bus_pkg.sv
// ram_bus_pkg: shared definitions for the RAM bus front-end.
//   state_t    - controller state encoding
//   DAT_WIDTH  - data width the merge helper operates on
//   BE_W       - byte-enable width (DAT_WIDTH/8)
//   byte_merge - per-byte select between an old word and new write data
package ram_bus_pkg;

  localparam int DAT_WIDTH = 32;
  localparam int BE_W      = DAT_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Byte i of the result comes from new_dat when be[i] is set, else from old_dat.
  function automatic logic [DAT_WIDTH-1:0] byte_merge(
    input logic [DAT_WIDTH-1:0] old_dat,
    input logic [DAT_WIDTH-1:0] new_dat,
    input logic [BE_W-1:0]      be
  );
    logic [DAT_WIDTH-1:0] merged;
    merged = old_dat;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_dat[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_dat[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: request/response front-end for a single-port synchronous RAM
// with a 1-cycle registered read. Full writes go straight through (1/cycle);
// partial writes are done as read-modify-write; reads return on a
// backpressure-tolerant response channel.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we/adr/dat/be        request fields (be ignored for reads)
//   resp_valid/resp_ready    response handshake (registered, held until taken)
//   resp_dat/resp_err        read data, out-of-range flag
//   ram_adr_o/dat_o/we_o     RAM pins (combinational from state/inputs)
//   ram_dat_i                RAM read data, valid the cycle after the address
// dat_width must equal ram_bus_pkg::DAT_WIDTH since the merge helper uses it.
module ram_bus_ctrl
  import ram_bus_pkg::*;
#(
  parameter int dat_width = DAT_WIDTH,
  parameter int adr_width = 32,
  parameter int mem_size  = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [adr_width-1:0]   req_adr,
  input  logic [dat_width-1:0]   req_dat,
  input  logic [dat_width/8-1:0] req_be,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [dat_width-1:0]   resp_dat,
  output logic                   resp_err,
  output logic [adr_width-1:0]   ram_adr_o,
  output logic [dat_width-1:0]   ram_dat_o,
  output logic                   ram_we_o,
  input  logic [dat_width-1:0]   ram_dat_i
);

  localparam int be_w = dat_width / 8;
  localparam logic [adr_width-1:0] MEM_LIMIT = adr_width'(mem_size);

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [adr_width-1:0]   adr_r;
  logic [dat_width-1:0]   dat_r;   // write data, replaced by the merged word in RMW_RD
  logic [be_w-1:0]        be_r;
  logic                   in_range_s;
  logic                   be_full_s;
  logic                   be_none_s;

  assign in_range_s = (req_adr < MEM_LIMIT);
  assign be_full_s  = &req_be;
  assign be_none_s  = ~|req_be;

  // Next-state decode and combinational RAM pin / req_ready drive.
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = 1'b0;
    ram_we_o    = 1'b0;
    ram_dat_o   = req_dat;
    ram_adr_o   = adr_r;
    case (state_r)
      IDLE: begin
        ram_adr_o = req_adr;
        req_ready = ~rst;
        if (req_valid && !rst) begin
          if (!req_we) begin
            if (in_range_s) begin
              state_nxt_s = RD;
            end else begin
              state_nxt_s = RESP;
            end
          end else if (in_range_s && be_full_s) begin
            ram_we_o = 1'b1;
          end else if (in_range_s && !be_none_s) begin
            state_nxt_s = RMW_RD;
          end else begin
            // be==0 or out of range: accepted and dropped
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD: begin
        state_nxt_s = RESP;
      end
      RMW_RD: begin
        state_nxt_s = RMW_WR;
      end
      RMW_WR: begin
        ram_we_o    = ~rst;
        ram_dat_o   = dat_r;
        state_nxt_s = IDLE;
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register, request latches and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      adr_r      <= {adr_width{1'b0}};
      dat_r      <= {dat_width{1'b0}};
      be_r       <= {be_w{1'b0}};
      resp_valid <= 1'b0;
      resp_dat   <= {dat_width{1'b0}};
      resp_err   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            adr_r <= req_adr;
            dat_r <= req_dat;
            be_r  <= req_be;
            if (!req_we && !in_range_s) begin
              resp_valid <= 1'b1;
              resp_dat   <= {dat_width{1'b0}};
              resp_err   <= 1'b1;
            end
          end
        end
        RD: begin
          resp_valid <= 1'b1;
          resp_dat   <= ram_dat_i;
          resp_err   <= 1'b0;
        end
        RMW_RD: begin
          dat_r <= byte_merge(ram_dat_i, dat_r, be_r);
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: begin
          resp_valid <= resp_valid;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// tb_ram_bus_ctrl: directed bench for ram_bus_ctrl with a behavioural RAM,
// a shadow memory and a response scoreboard.
module tb_ram_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = 32'd0;
  logic [31:0] req_dat = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_dat;
  logic        resp_err;
  logic [31:0] ram_adr_o;
  logic [31:0] ram_dat_o;
  logic        ram_we_o;
  logic [31:0] ram_q = 32'd0;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] mem    [0:1023] = '{default: 32'h0};
  logic [31:0] shadow [0:1023] = '{default: 32'h0};
  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt = 0;

  always #5 clk = ~clk;

  ram_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_dat(resp_dat), .resp_err(resp_err),
    .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o), .ram_we_o(ram_we_o),
    .ram_dat_i(ram_q)
  );

  // Behavioural single-port RAM with registered read (read-before-write).
  always @(posedge clk) begin
    if (ram_we_o && ram_adr_o < 32'd1024) mem[ram_adr_o[9:0]] <= ram_dat_o;
    ram_q <= mem[ram_adr_o[9:0]];
  end

  // Count every RAM write strobe.
  always @(posedge clk) begin
    if (ram_we_o) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge_model(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = {be[3] ? n[31:24] : o[31:24], be[2] ? n[23:16] : o[23:16],
         be[1] ? n[15:8]  : o[15:8],  be[0] ? n[7:0]   : o[7:0]};
    return r;
  endfunction

  // Scoreboard: pop an expectation on every response handshake.
  always @(negedge clk) begin
    resp_t e;
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_dat", resp_dat, e.dat);
        check("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  // Issue one request, wait for acceptance, update the model when asked.
  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] be, input bit upd);
    int n;
    req_we = we; req_adr = adr; req_dat = dat; req_be = be; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) check("req_timeout", 32'(req_ready), 32'd1);
    if (upd) begin
      if (!we) begin
        if (adr < 32'd1024) exp_q.push_back({shadow[adr[9:0]], 1'b0});
        else                exp_q.push_back({32'd0, 1'b1});
      end else if (adr < 32'd1024 && be != 4'd0) begin
        shadow[adr[9:0]] = merge_model(shadow[adr[9:0]], dat, be);
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [31:0] d0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_dat", resp_dat, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_we", 32'(ram_we_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Full write then read, latency check
    @(posedge clk); #1;
    send(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 1'b1);
    send(1'b0, 32'd5, 32'd0, 4'h0, 1'b1);
    @(negedge clk);
    check("rd_lat1_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("rd_lat2_valid", 32'(resp_valid), 32'd1);
    drain();

    // Partial write via RMW
    @(posedge clk); #1;
    send(1'b1, 32'd7, 32'h11223344, 4'hF, 1'b1);
    send(1'b1, 32'd7, 32'hAABBCCDD, 4'h5, 1'b1);
    @(negedge clk);
    check("rmw_ready1", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rmw_ready2", 32'(req_ready), 32'd0);
    check("rmw_we", 32'(ram_we_o), 32'd1);
    check("rmw_wdat", ram_dat_o, 32'h11BB33DD);
    @(negedge clk);
    check("rmw_ready3", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    send(1'b0, 32'd7, 32'd0, 4'h0, 1'b1);
    drain();

    // Response backpressure
    @(posedge clk); #1;
    resp_ready = 1'b0;
    send(1'b1, 32'd3, 32'hCAFEF00D, 4'hF, 1'b1);
    send(1'b0, 32'd3, 32'd0, 4'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    d0 = resp_dat;
    check("bp_first_dat", d0, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_dat_stable", resp_dat, d0);
      check("bp_ready_low", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_done", 32'(resp_valid), 32'd0);
    drain();

    // Out-of-range read and write
    @(posedge clk); #1;
    send(1'b0, 32'd1024, 32'd0, 4'h0, 1'b1);
    drain();
    w0 = wr_cnt;
    @(posedge clk); #1;
    send(1'b1, 32'd2000, 32'h12345678, 4'hF, 1'b1);
    send(1'b1, 32'd1024, 32'h12345678, 4'h3, 1'b1);
    repeat (3) @(negedge clk);
    check("oor_no_write", 32'(wr_cnt), 32'(w0));

    // Back-to-back full writes
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      req_we = 1'b1; req_adr = 32'(i); req_dat = 32'(i) * 32'h01010101;
      req_be = 4'hF; req_valid = 1'b1;
      shadow[i] = 32'(i) * 32'h01010101;
      @(negedge clk);
      check("burst_ready", 32'(req_ready), 32'd1);
      check("burst_we", 32'(ram_we_o), 32'd1);
      check("burst_adr", ram_adr_o, 32'(i));
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b0, 32'(i), 32'd0, 4'h0, 1'b1);
    drain();

    // Reset during RMW_RD
    @(posedge clk); #1;
    send(1'b1, 32'd9, 32'h55667788, 4'hF, 1'b1);
    w0 = wr_cnt + 0;
    @(negedge clk);
    w0 = wr_cnt;
    @(posedge clk); #1;
    send(1'b1, 32'd9, 32'hFFFFFFFF, 4'h3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rstrmw_we", 32'(ram_we_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstrmw_idle", 32'(req_ready), 32'd1);
    check("rstrmw_resp", 32'(resp_valid), 32'd0);
    check("rstrmw_we2", 32'(ram_we_o), 32'd0);
    repeat (2) @(negedge clk);
    check("rstrmw_nowrite", 32'(wr_cnt), 32'(w0));
    @(posedge clk); #1;
    send(1'b0, 32'd9, 32'd0, 4'h0, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
